// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage and its multiply/divide engine.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic             cancel_i;
  logic             stallreq_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_by_zero_o;

  // EX stage side: issues operations, consumes results
  modport master (
    output start_i, op_i, src_a_i, src_b_i, cancel_i,
    input  stallreq_o, done_o, hi_o, lo_o, div_by_zero_o
  );

  // Engine side
  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, cancel_i,
    output stallreq_o, done_o, hi_o, lo_o, div_by_zero_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU engine for the EX stage.
// One result bit per cycle on a shared 2*WIDTH accumulator; operands are
// handled as magnitudes and the sign is restored when the result is loaded.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     opb;
  logic                 is_div;
  logic                 is_signed;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 dbz;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 in_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic                 zero_div;
  logic                 accept;
  logic                 last_iter;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  // Operand conditioning: magnitudes and sign bits for the signed ops
  always_comb begin
    in_signed = ~bus.op_i[0];
    a_neg     = in_signed & bus.src_a_i[WIDTH-1];
    b_neg     = in_signed & bus.src_b_i[WIDTH-1];
    a_abs     = a_neg ? (WIDTH'(0) - bus.src_a_i) : bus.src_a_i;
    b_abs     = b_neg ? (WIDTH'(0) - bus.src_b_i) : bus.src_b_i;
    zero_div  = bus.op_i[1] & (bus.src_b_i == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; cancel wins over the final iteration
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_i && !bus.cancel_i) begin
          accept    = 1'b1;
          state_nxt = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.cancel_i) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(1)) begin
          last_iter = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  // Mult: acc = {partial product, remaining multiplier bits}, shifts right.
  // Div:  acc = {partial remainder, dividend/quotient bits}, shifts left.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign restoration of the final iteration's result (wraps modulo 2^WIDTH)
  always_comb begin
    prod_fix = (is_signed && neg_res) ? ((2*WIDTH)'(0) - acc_step) : acc_step;
    quo_fix  = (is_signed && neg_res) ? (WIDTH'(0) - acc_step[WIDTH-1:0])
                                      : acc_step[WIDTH-1:0];
    rem_fix  = (is_signed && neg_rem) ? (WIDTH'(0) - acc_step[2*WIDTH-1:WIDTH])
                                      : acc_step[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Datapath: capture at start, iterate in CALC, load hi/lo on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dbz       <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (accept) begin
      is_div    <= bus.op_i[1];
      is_signed <= in_signed;
      neg_res   <= a_neg ^ b_neg;
      neg_rem   <= a_neg;
      acc       <= {{WIDTH{1'b0}}, a_abs};
      opb       <= b_abs;
      cnt       <= CW'(WIDTH);
      dbz       <= zero_div;
      if (zero_div) begin
        hi_q <= bus.src_a_i;
        lo_q <= '1;
      end
    end else if (state == CALC && !bus.cancel_i) begin
      acc <= acc_step;
      cnt <= cnt - CW'(1);
      if (last_iter) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.stallreq_o    = ((state == IDLE) && bus.start_i) || (state == CALC);
  assign bus.done_o        = (state == DONE);
  assign bus.div_by_zero_o = (state == DONE) && dbz;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a cycle-timeline reference model checks
// every cycle, directed vectors check literal results and latencies.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result {div_by_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin up = ua * ub; return {1'b0, up}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {1'b0, ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Timeline model: an accepted op completes W+1 cycles later (1 for /0)
  bit          chk_en   = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_left   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;
  logic [31:0] p_hi     = '0;
  logic [31:0] p_lo     = '0;
  bit          p_dbz    = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      m_done = 1'b0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_active = 1'b0;
          m_hi     = p_hi;
          m_lo     = p_lo;
        end
      end
      chk("model done_o", {64'b0, bus.done_o}, {64'b0, m_done});
      chk("model div_by_zero_o", {64'b0, bus.div_by_zero_o}, {64'b0, m_done && p_dbz});
      chk("model stallreq_o", {64'b0, bus.stallreq_o},
          {64'b0, m_active || (!m_done && bus.start_i)});
      chk("model hi_o", {33'b0, bus.hi_o}, {33'b0, m_hi});
      chk("model lo_o", {33'b0, bus.lo_o}, {33'b0, m_lo});
      if (rst) begin
        m_active = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        p_dbz    = 1'b0;
      end else if (m_active && bus.cancel_i) begin
        m_active = 1'b0;
      end else if (!m_active && !m_done && bus.start_i && !bus.cancel_i) begin
        {p_dbz, p_hi, p_lo} = ref_op(bus.op_i, bus.src_a_i, bus.src_b_i);
        m_active = 1'b1;
        m_left   = p_dbz ? 1 : int'(W) + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble the inputs afterwards, wait (bounded) for done_o
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit edbz, input int elat);
    int t0;
    bit seen;
    bit stall_bad;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    t0 = cyc;
    @(negedge clk);
    chk({name, " stall@0"}, {64'b0, bus.stallreq_o}, 65'd1);
    tick();
    bus.start_i = 1'b0;
    bus.op_i    = 2'($urandom);
    bus.src_a_i = $urandom;
    bus.src_b_i = $urandom;
    seen      = 1'b0;
    stall_bad = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1'b1;
        if (bus.stallreq_o) stall_bad = 1'b1;
      end else if (!bus.stallreq_o) begin
        stall_bad = 1'b1;
      end
    end
    chk({name, " done seen"}, {64'b0, seen}, 65'd1);
    if (seen) begin
      chk({name, " latency"}, 65'(cyc - t0), 65'(elat));
      chk({name, " hi"}, {33'b0, bus.hi_o}, {33'b0, ehi});
      chk({name, " lo"}, {33'b0, bus.lo_o}, {33'b0, elo});
      chk({name, " dbz"}, {64'b0, bus.div_by_zero_o}, {64'b0, edbz});
      chk({name, " stall profile"}, {64'b0, stall_bad}, 65'd0);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int ndone;
    bit seen;

    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    bus.op_i     = 2'b00;
    bus.src_a_i  = '0;
    bus.src_b_i  = '0;

    // Pin the reference model against hand-computed results
    chk("ref MULTU max", ref_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
        {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    chk("ref MULT -2*3", ref_op(2'b00, 32'hFFFF_FFFE, 32'd3),
        {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    chk("ref DIV -7/2", ref_op(2'b10, 32'hFFFF_FFF9, 32'd2),
        {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("ref DIVU /0", ref_op(2'b11, 32'd100, 32'd0), {1'b1, 32'd100, 32'hFFFF_FFFF});
    chk("ref DIV ovf", ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF),
        {1'b0, 32'h0, 32'h8000_0000});
    chk("ref DIVU 2^31/3", ref_op(2'b11, 32'h8000_0000, 32'd3),
        {1'b0, 32'd2, 32'h2AAA_AAAA});

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset hi", {33'b0, bus.hi_o}, 65'd0);
    chk("reset lo", {33'b0, bus.lo_o}, 65'd0);
    chk("reset done", {64'b0, bus.done_o}, 65'd0);
    chk("reset dbz", {64'b0, bus.div_by_zero_o}, 65'd0);
    chk("reset stall", {64'b0, bus.stallreq_o}, 65'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 33);
    run_op("MULT -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33);
    run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("DIVU 100/0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("DIV 0/0", 2'b10, 32'h0, 32'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("MULT minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
    run_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    run_op("DIVU 2^31/3", 2'b11, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 1'b0, 33);

    // Cancel mid-divide: no completion, previous results retained
    bus.start_i = 1'b1;
    bus.op_i    = 2'b11;
    bus.src_a_i = 32'd50;
    bus.src_b_i = 32'd7;
    t0 = cyc;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 20 && cyc < t0 + 10; i++) tick();
    bus.cancel_i = 1'b1;
    tick();
    bus.cancel_i = 1'b0;
    @(negedge clk);
    chk("cancel idle stall", {64'b0, bus.stallreq_o}, 65'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    chk("cancel no done", {64'b0, seen}, 65'd0);
    chk("cancel hi kept", {33'b0, bus.hi_o}, 65'd2);
    chk("cancel lo kept", {33'b0, bus.lo_o}, {33'b0, 32'h2AAA_AAAA});
    tick();
    run_op("DIVU 50/7 restart", 2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0, 33);

    // Cancel together with start in IDLE blocks acceptance
    bus.start_i  = 1'b1;
    bus.cancel_i = 1'b1;
    bus.op_i     = 2'b01;
    bus.src_a_i  = 32'd9;
    bus.src_b_i  = 32'd9;
    tick();
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    chk("idle cancel blocks start", {64'b0, seen}, 65'd0);
    tick();

    // Start pulsed during CALC is ignored: exactly one completion
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.src_a_i = 32'd5;
    bus.src_b_i = 32'd6;
    t0 = cyc;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 20 && cyc < t0 + 5; i++) tick();
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src_a_i = 32'd1000;
    bus.src_b_i = 32'd1000;
    tick();
    bus.start_i = 1'b0;
    ndone = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    chk("busy start ignored done count", 65'(ndone), 65'd1);
    chk("busy start result lo", {33'b0, bus.lo_o}, 65'd30);
    chk("busy start result hi", {33'b0, bus.hi_o}, 65'd0);
    tick();

    // Reset in the middle of a MULT
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src_a_i = 32'd12345;
    bus.src_b_i = 32'hFFFF_FFFE;
    t0 = cyc;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 30 && cyc < t0 + 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midop reset hi", {33'b0, bus.hi_o}, 65'd0);
    chk("midop reset lo", {33'b0, bus.lo_o}, 65'd0);
    chk("midop reset done", {64'b0, bus.done_o}, 65'd0);
    chk("midop reset dbz", {64'b0, bus.div_by_zero_o}, 65'd0);
    chk("midop reset stall", {64'b0, bus.stallreq_o}, 65'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    chk("midop reset no done", {64'b0, seen}, 65'd0);
    tick();

    run_op("MULTU 0*x", 2'b01, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 33);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
